// File: rtl/pool_pkg.sv
// pool_pkg: mode encodings and geometry helpers
// shared by the streaming 2-D pooling engine.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  function automatic int idx_w(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  function automatic int acc_w(input int dw, input int k);
    return dw + 2 * clog2(k);
  endfunction

  function automatic int out_w(input int w, input int k);
    return w / k;
  endfunction

  function automatic bit k_legal(input int k);
    return (k == 2) || (k == 4);
  endfunction

endpackage

// File: rtl/pool_line_acc.sv
// pool_line_acc: one partial window result per
// output column, shared by all rows of a window.
module pool_line_acc
  import pool_pkg::*;
#(
  parameter int DEPTH = 14,
  parameter int WIDTH = 10,
  parameter int AW    = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool2d_stream_unit.sv
// pool2d_stream_unit: raster-stream KxK max/avg
// pooling with a single-entry output register.
module pool2d_stream_unit
  import pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL_K = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_last
);

  localparam int KW    = clog2(POOL_K);
  localparam int SH    = 2 * KW;
  localparam int ACC_W = acc_w(DATA_W, POOL_K);
  localparam int OUT_W = out_w(IMG_W, POOL_K);
  localparam int OUT_H = out_w(IMG_H, POOL_K);
  localparam int AW    = idx_w(OUT_W);
  localparam int CW    = idx_w(IMG_W + 1);
  localparam int RW    = idx_w(IMG_H + 1);

  localparam logic [CW-1:0] COL_END = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_END = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LIM = CW'(OUT_W * POOL_K);
  localparam logic [RW-1:0] ROW_LIM = RW'(OUT_H * POOL_K);
  localparam logic [CW-1:0] COL_LW  = CW'(OUT_W * POOL_K - 1);
  localparam logic [RW-1:0] ROW_LW  = RW'(OUT_H * POOL_K - 1);
  localparam logic [KW-1:0] K_END   = '1;

  if (!k_legal(POOL_K)) begin : g_bad_k
    $error("pool2d_stream_unit: POOL_K must be 2 or 4");
  end

  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;
  pool_mode_e           r_mode;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic [CH*DATA_W-1:0] r_out_data;

  logic                 w_fire;
  logic                 w_frame_start;
  logic                 w_in_grid;
  logic                 w_first;
  logic                 w_wlast;
  logic                 w_frame_last;
  logic                 w_we;
  pool_mode_e           w_mode;
  logic [AW-1:0]        w_addr;
  logic [CH*ACC_W-1:0]  w_rdata;
  logic [CH*ACC_W-1:0]  w_wdata;
  logic [CH*DATA_W-1:0] w_result;

  assign in_ready  = !r_out_valid || out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

  assign w_fire        = in_valid && in_ready;
  assign w_frame_start = (r_col == '0) && (r_row == '0);
  // The opening beat already pools with the mode it latches.
  assign w_mode    = w_frame_start ? pool_mode_e'(mode) : r_mode;
  assign w_in_grid = (r_col < COL_LIM) && (r_row < ROW_LIM);
  assign w_first   = (r_col[KW-1:0] == '0) &&
                     (r_row[KW-1:0] == '0);
  assign w_wlast   = (r_col[KW-1:0] == K_END) &&
                     (r_row[KW-1:0] == K_END);
  assign w_frame_last = (r_col == COL_LW) && (r_row == ROW_LW);
  assign w_we   = w_fire && w_in_grid && !w_wlast;
  assign w_addr = AW'(r_col >> KW);

  pool_line_acc #(
    .DEPTH (OUT_W),
    .WIDTH (CH * ACC_W),
    .AW    (AW)
  ) u_acc (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_addr),
    .i_wdata (w_wdata),
    .i_raddr (w_addr),
    .o_rdata (w_rdata)
  );

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [ACC_W-1:0] w_pix;
    logic [ACC_W-1:0] w_old;
    logic [ACC_W-1:0] w_cmb;

    assign w_pix = ACC_W'(in_data[c*DATA_W +: DATA_W]);
    assign w_old = w_rdata[c*ACC_W +: ACC_W];
    assign w_cmb = w_first ? w_pix :
                   (w_mode == POOL_AVG) ? w_old + w_pix :
                   (w_pix > w_old) ? w_pix : w_old;
    assign w_wdata[c*ACC_W +: ACC_W] = w_cmb;
    // Sum of K*K samples: dropping the low SH bits is the mean.
    assign w_result[c*DATA_W +: DATA_W] =
      (w_mode == POOL_AVG) ? w_cmb[SH +: DATA_W]
                           : w_cmb[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_mode <= POOL_MAX;
    end else if (w_fire) begin
      if (w_frame_start) r_mode <= pool_mode_e'(mode);
      if (r_col == COL_END) begin
        r_col <= '0;
        r_row <= (r_row == ROW_END) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (out_ready) r_out_valid <= 1'b0;
      if (w_fire && w_in_grid && w_wlast) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
        r_out_last  <= w_frame_last;
      end
    end
  end

endmodule
